// File: rtl/load_store_unit.sv
// Load/store unit driving a 64-bit word-wide data memory without byte enables.
// Sub-word stores are done as read-modify-write; bad requests complete with resp_err.
module load_store_unit #(
  parameter int ADDR_W = 9,
  parameter int XLEN   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

  state_t            state_reg, state_next;
  logic [2:0]        funct3_reg;
  logic [2:0]        off_reg;
  logic              we_reg;
  logic [XLEN-1:0]   wdata_reg;

  logic              accept;
  logic              misaligned;
  logic              req_err;
  logic              full_store;
  logic [XLEN-1:0]   rdata_shift;
  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   wdata_shift;
  logic [XLEN-1:0]   merged_word;
  logic [3:0]        nbytes;
  logic [7:0]        lane_sel;

  assign accept     = req_valid && req_ready;
  assign full_store = req_we && (req_funct3[1:0] == 2'b11);

  always_comb begin
    misaligned = 1'b0;
    case (req_funct3[1:0])
      2'b01:   misaligned = req_addr[0];
      2'b10:   misaligned = |req_addr[1:0];
      2'b11:   misaligned = |req_addr[2:0];
      default: misaligned = 1'b0;
    endcase
    req_err = misaligned
           || (req_funct3 == 3'b111)
           || (req_we && req_funct3[2])
           || (|req_addr[XLEN-1:ADDR_W+3]);
  end

  // Load lane extraction: shift the addressed bytes down to bit 0, then extend.
  assign rdata_shift = mem_rdata >> {off_reg, 3'b000};

  always_comb begin
    load_data = '0;
    case (funct3_reg)
      3'b000:  load_data = {{(XLEN-8){rdata_shift[7]}},   rdata_shift[7:0]};
      3'b001:  load_data = {{(XLEN-16){rdata_shift[15]}}, rdata_shift[15:0]};
      3'b010:  load_data = {{(XLEN-32){rdata_shift[31]}}, rdata_shift[31:0]};
      3'b011:  load_data = rdata_shift;
      3'b100:  load_data = {{(XLEN-8){1'b0}},  rdata_shift[7:0]};
      3'b101:  load_data = {{(XLEN-16){1'b0}}, rdata_shift[15:0]};
      3'b110:  load_data = {{(XLEN-32){1'b0}}, rdata_shift[31:0]};
      default: load_data = '0;
    endcase
  end

  // Store merge: each byte lane picks new data if it lies in off..off+n-1.
  assign nbytes      = 4'd1 << funct3_reg[1:0];
  assign wdata_shift = wdata_reg << {off_reg, 3'b000};

  for (genvar gi = 0; gi < XLEN / 8; gi++) begin : g_lane
    assign lane_sel[gi] = (4'(gi) >= {1'b0, off_reg}) && (4'(gi) < ({1'b0, off_reg} + nbytes));
    assign merged_word[8*gi +: 8] = lane_sel[gi] ? wdata_shift[8*gi +: 8] : mem_rdata[8*gi +: 8];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = rst_n;
        if (accept) begin
          if (req_err)         state_next = RESP;
          else if (full_store) state_next = WR;
          else                 state_next = RD;
        end
      end
      RD:   state_next = we_reg ? WR : RESP;
      WR: begin
        mem_we     = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      funct3_reg <= '0;
      off_reg    <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            funct3_reg <= req_funct3;
            off_reg    <= req_addr[2:0];
            we_reg     <= req_we;
            wdata_reg  <= req_wdata;
            resp_rdata <= '0;
            resp_err   <= req_err;
            // Errored requests never touch memory, so mem_addr keeps its value.
            if (!req_err) mem_addr <= req_addr[ADDR_W+2:3];
            if (!req_err && full_store) mem_wdata <= req_wdata;
          end
        end
        RD: begin
          if (we_reg) mem_wdata  <= merged_word;
          else        resp_rdata <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory model,
// randomized and directed requests, decoupled monitor checking every response.
module tb_load_store_unit;

  localparam int ADDR_W = 9;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
    int          we_cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_funct3 = '0;
  logic [63:0]       req_addr = '0;
  logic [63:0]       req_wdata = '0;
  logic              resp_valid;
  logic              resp_ready = 1'b0;
  logic [63:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [63:0]       mem_wdata;
  logic [63:0]       mem_rdata;

  logic [63:0] mem     [DEPTH];
  logic [63:0] ref_mem [DEPTH];

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   hold_cnt = 0;
  bit   mon_busy = 1'b0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .XLEN(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_we     (mem_we),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: byte-addressed view of ref_mem, updated at issue time.
  task automatic model(input logic we, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, output exp_t e);
    int n, off, idx;
    logic [63:0] w, v;
    n   = 1 << f3[1:0];
    off = int'(a % 8);
    e.rdata = '0; e.err = 1'b0; e.lat = 0; e.we_cyc = 0;
    if (f3 == 3'b111 || (we && f3[2]) || (a % 64'(n)) != 0 || a >= 64'(DEPTH * 8)) begin
      e.err = 1'b1;
      e.lat = 1;
      return;
    end
    idx = int'(a / 8);
    w   = ref_mem[idx];
    if (!we) begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
      if (!f3[2] && n < 8 && v[8*n-1])
        for (int i = n; i < 8; i++) v[8*i +: 8] = 8'hFF;
      e.rdata = v;
      e.lat   = 2;
    end else begin
      for (int i = 0; i < n; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
      ref_mem[idx] = w;
      e.lat    = (n == 8) ? 2 : 3;
      e.we_cyc = (n == 8) ? 1 : 2;
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] wd, input exp_t e);
    bit ok = 1'b0;
    exp_q.push_back(e);
    $display("REQ we=%0d f3=%0d addr=%h wdata=%h exp_rdata=%h exp_err=%0d",
             we, f3, a, wd, e.rdata, e.err);
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd; req_valid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got req_ready=0 expected 1 within 100 cycles");
      void'(exp_q.pop_back());
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
  endtask

  task automatic issue_model(input logic we, input logic [2:0] f3, input logic [63:0] a,
                             input logic [63:0] wd);
    exp_t e;
    model(we, f3, a, wd, e);
    issue(we, f3, a, wd, e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (exp_q.size() != 0 || mon_busy); i++) begin
      @(posedge clk); #1;
    end
    if (exp_q.size() != 0 || mon_busy) begin
      n_cmp++; n_bad++;
      $display("FAIL idle_timeout: got %0d pending expected 0", exp_q.size());
    end
  endtask

  initial begin : resp_driver
    forever begin
      @(posedge clk); #1;
      if (hold_cnt > 0) begin
        resp_ready = 1'b0;
        hold_cnt--;
      end else begin
        resp_ready = ($urandom_range(0, 3) != 0);
      end
    end
  end

  initial begin : monitor
    int cyc, we_cnt, we_last;
    bit seen;
    exp_t e;
    logic [63:0] held_rdata;
    logic held_err;
    cyc = 0; we_cnt = 0; we_last = 0; seen = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_busy = 1'b0;
        seen = 1'b0;
      end else if (mon_busy) begin
        cyc++;
        if (mem_we) begin we_cnt++; we_last = cyc; end
        check("req_ready_busy", 64'(req_ready), 64'd0);
        if (resp_valid && !seen) begin
          if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_resp: got rdata=%h err=%0d expected none", resp_rdata, resp_err);
          end else begin
            e = exp_q.pop_front();
            $display("RSP rdata=%h err=%0d cycle=%0d we_pulses=%0d", resp_rdata, resp_err, cyc, we_cnt);
            check("resp_rdata", resp_rdata, e.rdata);
            check("resp_err", 64'(resp_err), 64'(e.err));
            check("latency", 64'(cyc), 64'(e.lat));
            check("we_pulses", 64'(we_cnt), (e.we_cyc != 0) ? 64'd1 : 64'd0);
            if (e.we_cyc != 0) check("we_cycle", 64'(we_last), 64'(e.we_cyc));
          end
          seen = 1'b1;
          held_rdata = resp_rdata;
          held_err = resp_err;
        end else if (resp_valid) begin
          check("rdata_stable", resp_rdata, held_rdata);
          check("err_stable", 64'(resp_err), 64'(held_err));
        end
        if (resp_valid && resp_ready) mon_busy = 1'b0;
        if (!seen && cyc > 20) begin
          n_cmp++; n_bad++;
          $display("FAIL resp_timeout: got no resp_valid expected one within 20 cycles");
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          mon_busy = 1'b0;
        end
      end else begin
        check("idle_mem_we", 64'(mem_we), 64'd0);
        check("idle_resp_valid", 64'(resp_valid), 64'd0);
        if (req_valid && req_ready) begin
          mon_busy = 1'b1;
          cyc = 0; we_cnt = 0; we_last = 0; seen = 1'b0;
        end
      end
    end
  end

  initial begin : stimulus
    exp_t e;
    logic [63:0] v, a;
    logic [2:0] f3;
    logic we;
    int idx, off, n;

    for (int i = 0; i < DEPTH; i++) begin
      v = {$urandom, $urandom};
      mem[i] <= v;
      ref_mem[i] = v;
    end

    // Reset values while rst_n is low
    #12;
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("rst_req_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;

    // 1. LD 0x10
    mem[2] <= 64'h1122334455667788; ref_mem[2] = 64'h1122334455667788;
    model(1'b0, 3'b011, 64'h10, 64'h0, e);
    e.rdata = 64'h1122334455667788; e.err = 1'b0; e.lat = 2; e.we_cyc = 0;
    issue(1'b0, 3'b011, 64'h10, 64'h0, e);
    wait_idle();

    // 2. LB / LBU 0x17 with byte 7 = 0x80
    mem[2] <= 64'h8011223344556677; ref_mem[2] = 64'h8011223344556677;
    model(1'b0, 3'b000, 64'h17, 64'h0, e);
    e.rdata = 64'hFFFF_FFFF_FFFF_FF80;
    issue(1'b0, 3'b000, 64'h17, 64'h0, e);
    model(1'b0, 3'b100, 64'h17, 64'h0, e);
    e.rdata = 64'h80;
    issue(1'b0, 3'b100, 64'h17, 64'h0, e);
    wait_idle();

    // 3. SB 0x11 data 0xAB
    mem[2] <= 64'h1122334455667788; ref_mem[2] = 64'h1122334455667788;
    model(1'b1, 3'b000, 64'h11, 64'hAB, e);
    e.rdata = '0; e.err = 1'b0; e.lat = 3; e.we_cyc = 2;
    issue(1'b1, 3'b000, 64'h11, 64'hFFFF_FFFF_FFFF_FFAB, e);
    wait_idle();
    check("sb_merge_mem", mem[2], 64'h112233445566AB88);

    // 4. Misaligned LW and out-of-range SD
    e.rdata = '0; e.err = 1'b1; e.lat = 1; e.we_cyc = 0;
    issue(1'b0, 3'b010, 64'h12, 64'h0, e);
    issue(1'b1, 3'b011, 64'h1010, 64'hDEAD_BEEF_0000_0001, e);
    wait_idle();
    check("oob_sd_mem", mem[2], 64'h112233445566AB88);

    // 5. Held response while a second request waits
    hold_cnt = 9;
    issue_model(1'b0, 3'b001, 64'h16, 64'h0);
    issue_model(1'b0, 3'b110, 64'h14, 64'h0);
    wait_idle();

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      we  = 1'($urandom);
      f3  = 3'($urandom);
      n   = 1 << f3[1:0];
      idx = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
      off = $urandom_range(0, 7);
      if ($urandom_range(0, 3) != 0) off = off & ~(n - 1);
      a = 64'(idx * 8 + off);
      if ($urandom_range(0, 15) == 0) a[$urandom_range(12, 63)] = 1'b1;
      issue_model(we, f3, a, {$urandom, $urandom});
    end
    wait_idle();

    // 6. Reset during RD of a halfword store
    mem[2] <= 64'h1122334455667788; ref_mem[2] = 64'h1122334455667788;
    req_we = 1'b1; req_funct3 = 3'b001; req_addr = 64'h12; req_wdata = 64'hBEEF;
    req_valid = 1'b1;
    @(negedge clk);
    check("sh_ready", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_mem_we", 64'(mem_we), 64'd0);
    check("abort_mem_addr", 64'(mem_addr), 64'd0);
    check("abort_mem_wdata", mem_wdata, 64'd0);
    check("abort_resp_valid", 64'(resp_valid), 64'd0);
    check("abort_resp_rdata", resp_rdata, 64'd0);
    check("abort_resp_err", 64'(resp_err), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("abort_mem_unchanged", mem[2], 64'h1122334455667788);
    rst_n = 1'b1;
    #1;
    check("abort_req_ready_after", 64'(req_ready), 64'd1);
    @(posedge clk); #1;
    issue_model(1'b0, 3'b011, 64'h10, 64'h0);
    wait_idle();

    for (int i = 0; i < DEPTH; i++) check($sformatf("mem_final[%0d]", i), mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
